// File: rtl/arbitrated_memory_interface_if.sv
// Shared memory-port bus between the arbiter front end and the unified memory/cache.
// The master side issues requests. The slave side accepts them and returns in-order read responses.
interface arbitrated_memory_interface_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 32
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic                    mem_read;
  logic                    mem_write;
  logic [BE_W-1:0]         mem_byte_en;
  logic [ADDRESS_BITS-1:0] mem_address_in;
  logic [DATA_WIDTH-1:0]   mem_data_in;
  logic                    mem_ready;
  logic                    mem_valid;
  logic [DATA_WIDTH-1:0]   mem_data_out;
  logic [ADDRESS_BITS-1:0] mem_address_out;

  modport master (
    output mem_read, mem_write, mem_byte_en, mem_address_in, mem_data_in,
    input  mem_ready, mem_valid, mem_data_out, mem_address_out
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_en, mem_address_in, mem_data_in,
    output mem_ready, mem_valid, mem_data_out, mem_address_out
  );
endinterface

// File: rtl/arbitrated_memory_interface.sv
// Merges the fetch and memory-stage requests onto one shared memory port.
// In-order read responses are routed back to the originating stage through a requester-tag FIFO.
module arbitrated_memory_interface #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDRESS_BITS    = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          ROUND_ROBIN     = 1'b0,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      fetch_read,
  input  logic [ADDRESS_BITS-1:0]   fetch_address_out,
  output logic                      fetch_ready,
  output logic                      fetch_valid,
  output logic [DATA_WIDTH-1:0]     fetch_data_in,
  output logic [ADDRESS_BITS-1:0]   fetch_address_in,
  input  logic                      memory_read,
  input  logic                      memory_write,
  input  logic [DATA_WIDTH/8-1:0]   memory_byte_en,
  input  logic [ADDRESS_BITS-1:0]   memory_address_out,
  input  logic [DATA_WIDTH-1:0]     memory_data_out,
  output logic                      memory_ready,
  output logic                      memory_valid,
  output logic [DATA_WIDTH-1:0]     memory_data_in,
  output logic [ADDRESS_BITS-1:0]   memory_address_in,
  arbitrated_memory_interface_if.master mem,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      resp_error
);
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {GRANT_FETCH = 1'b0, GRANT_MEM = 1'b1} grant_e;

  grant_e                     last_grant_q, last_grant_d;
  logic                       mem_req, can_issue, grant_fetch, grant_mem;
  logic                       push, pop, head_tag;
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;

  assign mem_req   = memory_read | memory_write;
  assign can_issue = mem.mem_ready & (outstanding != FULL_CNT);

  // Last-grant register only moves on a conflict that actually issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_grant_q <= GRANT_FETCH;
    else        last_grant_q <= last_grant_d;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    grant_mem    = 1'b0;
    grant_fetch  = 1'b0;
    if (fetch_read && mem_req) begin
      if (ROUND_ROBIN) grant_mem = (last_grant_q == GRANT_FETCH);
      else             grant_mem = 1'b1;
      grant_fetch = ~grant_mem;
      if (can_issue) last_grant_d = grant_mem ? GRANT_MEM : GRANT_FETCH;
    end else begin
      grant_mem   = mem_req;
      grant_fetch = fetch_read;
    end
  end

  // Shared-port request mux and stage readies; everything idles at zero with no request.
  always_comb begin
    fetch_ready        = can_issue & grant_fetch;
    memory_ready       = can_issue & grant_mem;
    mem.mem_read       = 1'b0;
    mem.mem_write      = 1'b0;
    mem.mem_byte_en    = '0;
    mem.mem_address_in = '0;
    mem.mem_data_in    = '0;
    if (grant_mem) begin
      mem.mem_read       = can_issue & memory_read;
      mem.mem_write      = can_issue & memory_write;
      mem.mem_byte_en    = memory_byte_en;
      mem.mem_address_in = memory_address_out;
      mem.mem_data_in    = memory_data_out;
    end else if (grant_fetch) begin
      mem.mem_read       = can_issue;
      mem.mem_byte_en    = {BE_W{1'b1}};
      mem.mem_address_in = fetch_address_out;
    end
  end

  assign push     = can_issue & ((grant_fetch & fetch_read) | (grant_mem & memory_read));
  assign pop      = mem.mem_valid & (outstanding != '0);
  assign head_tag = tag_q[rd_ptr_q];

  // Requester-tag FIFO: 0 = fetch, 1 = memory stage; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      outstanding <= '0;
      resp_error  <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= grant_mem;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      outstanding <= outstanding + CNT_W'(push) - CNT_W'(pop);
      if (mem.mem_valid && outstanding == '0) resp_error <= 1'b1;
    end
  end

  // Registered response path; the non-addressed stage keeps its last data/address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_valid       <= 1'b0;
      fetch_data_in     <= '0;
      fetch_address_in  <= '0;
      memory_valid      <= 1'b0;
      memory_data_in    <= '0;
      memory_address_in <= '0;
    end else begin
      fetch_valid  <= pop & ~head_tag;
      memory_valid <= pop & head_tag;
      if (pop && !head_tag) begin
        fetch_data_in    <= mem.mem_data_out;
        fetch_address_in <= mem.mem_address_out;
      end
      if (pop && head_tag) begin
        memory_data_in    <= mem.mem_data_out;
        memory_address_in <= mem.mem_address_out;
      end
    end
  end
endmodule
